// File: rtl/srl_tap_window.sv
// -----------------------------------------------------------------------------
// srl_tap_window
//
// Tap window feeding the FIR bank. An asynchronous sample strobe is
// synchronised and edge-detected. Each accepted offset-binary sample is
// converted to two's complement and decimated. Kept samples shift into an
// NUM_TAPS-deep window. The block keeps a running signed sum of the window and
// offers every full window to the FIRs through a ready/start handshake.
//
// Build option:
//   SRL_TAP_WINDOW_SUM_EN  defined   -> running-sum adder present, o_sum valid
//                          undefined -> no adder, o_sum tied to 0
//
// Ports:
//   clk            system clock
//   rst_n          asynchronous active-low reset
//   i_value        offset-binary sample, stable >=4 clk after i_data_clk rises
//   i_data_clk     asynchronous sample strobe, rising edge = new sample
//   i_decim        keep 1 of every (i_decim+1) accepted samples (quasi-static)
//   i_clear        synchronous flush of window, sum, counters and overrun
//   i_fir_ready    FIRs idle and able to start a calculation
//   o_start_calc   one-cycle start pulse to the FIRs
//   o_taps         window, newest sample in the least significant element
//   o_sum          signed sum of all taps
//   o_window_full  NUM_TAPS samples shifted in since reset/clear
//   o_overrun      sticky: a full window was replaced before the FIRs took it
// -----------------------------------------------------------------------------
module srl_tap_window #(
    parameter int BITS_PER_ELEM = 8,
    parameter int NUM_TAPS      = 9,
    parameter int DECIM_W       = 4,
    localparam int SUM_W        = BITS_PER_ELEM + $clog2(NUM_TAPS) + 1
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [BITS_PER_ELEM-1:0]           i_value,
    input  logic                               i_data_clk,
    input  logic [DECIM_W-1:0]                 i_decim,
    input  logic                               i_clear,
    input  logic                               i_fir_ready,
    output logic                               o_start_calc,
    output logic [BITS_PER_ELEM*NUM_TAPS-1:0]  o_taps,
    output logic signed [SUM_W-1:0]            o_sum,
    output logic                               o_window_full,
    output logic                               o_overrun
);

    localparam int B      = BITS_PER_ELEM;
    localparam int FILL_W = $clog2(NUM_TAPS + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PEND = 2'd1,
        FIRE = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Strobe synchroniser and edge detect.
    // Bits [1:0] are the metastability pair. Bit [2] is the delayed copy
    // used for rising-edge detection. accept_reg is high in the third
    // cycle after the strobe rises. The converted sample is captured in
    // the same cycle, while i_value is guaranteed stable.
    // ------------------------------------------------------------------
    logic [2:0]          sync_reg;
    logic                accept_reg;
    logic signed [B-1:0] elem_reg;
    logic                rise_det;

    assign rise_det = sync_reg[1] & ~sync_reg[2];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_reg   <= '0;
            accept_reg <= 1'b0;
            elem_reg   <= '0;
        end else begin
            sync_reg   <= {sync_reg[1:0], i_data_clk};
            accept_reg <= rise_det;
            if (rise_det) begin
                // Offset binary to two's complement: invert the MSB.
                elem_reg <= {~i_value[B-1], i_value[B-2:0]};
            end
        end
    end

    // ------------------------------------------------------------------
    // Decimation. The >= comparison also recovers cleanly if i_decim is
    // lowered below the current count; otherwise it behaves like ==.
    // ------------------------------------------------------------------
    logic [DECIM_W-1:0] dcnt_reg;
    logic               keep;
    logic               shift;

    assign keep  = accept_reg && (dcnt_reg >= i_decim);
    // A clear in the same cycle drops the sample.
    assign shift = keep && !i_clear;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dcnt_reg <= '0;
        end else if (i_clear) begin
            dcnt_reg <= '0;
        end else if (accept_reg) begin
            dcnt_reg <= keep ? '0 : dcnt_reg + DECIM_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Tap shift register; element 0 holds the newest sample.
    // ------------------------------------------------------------------
    logic signed [B-1:0] taps_reg [NUM_TAPS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            taps_reg[0] <= '0;
        end else if (i_clear) begin
            taps_reg[0] <= '0;
        end else if (shift) begin
            taps_reg[0] <= elem_reg;
        end
    end

    for (genvar gi = 1; gi < NUM_TAPS; gi++) begin : g_tap
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                taps_reg[gi] <= '0;
            end else if (i_clear) begin
                taps_reg[gi] <= '0;
            end else if (shift) begin
                taps_reg[gi] <= taps_reg[gi-1];
            end
        end
    end

    for (genvar gi = 0; gi < NUM_TAPS; gi++) begin : g_pack
        assign o_taps[gi*B +: B] = taps_reg[gi];
    end

    // ------------------------------------------------------------------
    // Fill counter and window-full flag.
    // ------------------------------------------------------------------
    logic [FILL_W-1:0] fill_reg;
    logic              full_reg;
    logic              fills_window;

    // True when this shift leaves (or keeps) the window full.
    assign fills_window = (fill_reg >= FILL_W'(NUM_TAPS - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fill_reg <= '0;
            full_reg <= 1'b0;
        end else if (i_clear) begin
            fill_reg <= '0;
            full_reg <= 1'b0;
        end else if (shift) begin
            if (fill_reg != FILL_W'(NUM_TAPS)) begin
                fill_reg <= fill_reg + FILL_W'(1);
            end
            full_reg <= fills_window;
        end
    end

    assign o_window_full = full_reg;

    // ------------------------------------------------------------------
    // Running sum. The discarded oldest tap is still zero while the
    // window fills, so no special case is needed. SUM_W covers
    // NUM_TAPS * min(elem), so no saturation is required.
    // ------------------------------------------------------------------
`ifdef SRL_TAP_WINDOW_SUM_EN
    logic signed [SUM_W-1:0] sum_reg;
    logic signed [SUM_W-1:0] elem_sx;
    logic signed [SUM_W-1:0] oldest_sx;

    assign elem_sx   = {{(SUM_W-B){elem_reg[B-1]}}, elem_reg};
    assign oldest_sx = {{(SUM_W-B){taps_reg[NUM_TAPS-1][B-1]}}, taps_reg[NUM_TAPS-1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_reg <= '0;
        end else if (i_clear) begin
            sum_reg <= '0;
        end else if (shift) begin
            sum_reg <= sum_reg + elem_sx - oldest_sx;
        end
    end

    assign o_sum = sum_reg;
`else
    assign o_sum = '0;
`endif

    // ------------------------------------------------------------------
    // Handshake FSM: state register / next-state logic / output register.
    // ------------------------------------------------------------------
    state_t state_reg;
    state_t state_next;
    logic   start_reg;
    logic   start_next;
    logic   overrun_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            IDLE: if (shift && fills_window) state_next = PEND;
            // A new shift while pending keeps us pending. The FIRs then
            // receive the newest window once they become ready.
            PEND: if (!shift && i_fir_ready) state_next = FIRE;
            FIRE: state_next = shift ? PEND : IDLE;
            default: state_next = IDLE;
        endcase
        if (i_clear) begin
            state_next = IDLE;
        end
    end

    // The start pulse is registered so that it coincides exactly with
    // the FIRE state.
    always_comb begin
        start_next = (state_next == FIRE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_reg   <= 1'b0;
            overrun_reg <= 1'b0;
        end else begin
            start_reg <= start_next;
            if (i_clear) begin
                overrun_reg <= 1'b0;
            end else if (shift && state_reg == PEND) begin
                overrun_reg <= 1'b1;
            end
        end
    end

    assign o_start_calc = start_reg;
    assign o_overrun    = overrun_reg;

endmodule

// File: tb/tb_srl_tap_window.sv
module tb_srl_tap_window;

    localparam int B  = 8;
    localparam int N  = 9;
    localparam int DW = 4;
    localparam int SW = B + $clog2(N) + 1;

    logic                 clk;
    logic                 rst_n;
    logic [B-1:0]         i_value;
    logic                 i_data_clk;
    logic [DW-1:0]        i_decim;
    logic                 i_clear;
    logic                 i_fir_ready;
    logic                 o_start_calc;
    logic [B*N-1:0]       o_taps;
    logic signed [SW-1:0] o_sum;
    logic                 o_window_full;
    logic                 o_overrun;

    srl_tap_window #(.BITS_PER_ELEM(B), .NUM_TAPS(N), .DECIM_W(DW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_value      (i_value),
        .i_data_clk   (i_data_clk),
        .i_decim      (i_decim),
        .i_clear      (i_clear),
        .i_fir_ready  (i_fir_ready),
        .o_start_calc (o_start_calc),
        .o_taps       (o_taps),
        .o_sum        (o_sum),
        .o_window_full(o_window_full),
        .o_overrun    (o_overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests;
    int fails;

    // Start pulses observed, sampled mid-cycle.
    int start_cnt;
    initial start_cnt = 0;
    always @(negedge clk) if (o_start_calc === 1'b1) start_cnt++;

    // Behavioural model: the window as a list of signed integers, newest first.
    int win[$];
    int dcnt_m;
    int decim_m;
    int exp_pulses;

    function automatic int conv(input logic [B-1:0] v);
        return int'(v) - (1 << (B-1));
    endfunction

    function automatic logic [B*N-1:0] exp_taps();
        logic [B*N-1:0] r;
        int             val;
        r = '0;
        for (int k = 0; k < N; k++) begin
            val = (k < win.size()) ? win[k] : 0;
            r[k*B +: B] = val[B-1:0];
        end
        return r;
    endfunction

    function automatic logic signed [SW-1:0] exp_sum();
        int s;
        s = 0;
`ifdef SRL_TAP_WINDOW_SUM_EN
        foreach (win[k]) s += win[k];
`endif
        return SW'(s);
    endfunction

    task automatic model_reset();
        win.delete();
        dcnt_m = 0;
    endtask

    task automatic model_push(input logic [B-1:0] v);
        if (dcnt_m >= decim_m) begin
            win.push_front(conv(v));
            if (win.size() > N) void'(win.pop_back());
            dcnt_m = 0;
            if (win.size() == N) exp_pulses++;
        end else begin
            dcnt_m++;
        end
    endtask

    task automatic do_reset();
        i_data_clk = 1'b0;
        i_clear    = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        model_reset();
    endtask

    // One strobe: rise, hold high for 'hold' cycles, then low for 4 cycles.
    task automatic strobe(input logic [B-1:0] v, input int hold);
        i_value    = v;
        i_data_clk = 1'b1;
        repeat (hold) @(negedge clk);
        i_data_clk = 1'b0;
        repeat (4) @(negedge clk);
        model_push(v);
    endtask

    task automatic pulse_clear();
        i_clear = 1'b1;
        @(negedge clk);
        i_clear = 1'b0;
        @(negedge clk);
        model_reset();
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        i_fir_ready = 1'b1;
        i_decim     = '0;
        decim_m     = 0;
        do_reset();
        tests++;
        if (o_taps !== '0 || o_sum !== '0 || o_window_full !== 1'b0 ||
            o_overrun !== 1'b0 || o_start_calc !== 1'b0) begin
            fails++;
            $display("FAIL reset: taps=%h sum=%0d full=%b ovr=%b start=%b, required all zero",
                     o_taps, o_sum, o_window_full, o_overrun, o_start_calc);
        end
        $display("[TB] reset checked");
    endtask

    task automatic test_fill();
        int base;
        do_reset();
        base = start_cnt;
        for (int i = 0; i < N; i++) begin
            strobe(8'h81, 6);
            tests++;
            if (o_taps !== exp_taps() || o_sum !== exp_sum() ||
                o_window_full !== (win.size() == N)) begin
                fails++;
                $display("FAIL fill[%0d]: taps=%h sum=%0d full=%b, required taps=%h sum=%0d full=%b",
                         i, o_taps, o_sum, o_window_full, exp_taps(), exp_sum(), win.size() == N);
            end
            $display("[TB] fill strobe %0d taps=%h sum=%0d", i, o_taps, o_sum);
        end
        tests++;
        if (start_cnt - base !== 1) begin
            fails++;
            $display("FAIL fill_start: pulses=%0d, required 1", start_cnt - base);
        end
    endtask

    task automatic test_conversion();
        logic [B-1:0] vals [3];
        logic [B-1:0] prev_tap;
        vals[0] = 8'h00;
        vals[1] = 8'hFF;
        vals[2] = 8'h80;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            prev_tap   = o_taps[B-1:0];
            i_value    = vals[i];
            i_data_clk = 1'b1;
            repeat (3) @(negedge clk);
            tests++;
            if (o_taps[B-1:0] !== prev_tap) begin
                fails++;
                $display("FAIL latency_early[%0d]: tap0=%h, required %h", i, o_taps[B-1:0], prev_tap);
            end
            @(negedge clk);
            model_push(vals[i]);
            tests++;
            if (o_taps !== exp_taps() || o_sum !== exp_sum()) begin
                fails++;
                $display("FAIL convert[%0d]: taps=%h sum=%0d, required taps=%h sum=%0d",
                         i, o_taps, o_sum, exp_taps(), exp_sum());
            end
            $display("[TB] convert in=%h tap0=%h sum=%0d", vals[i], o_taps[B-1:0], o_sum);
            repeat (2) @(negedge clk);
            i_data_clk = 1'b0;
            repeat (4) @(negedge clk);
        end
    endtask

    task automatic test_drop_oldest();
        do_reset();
        for (int i = 0; i < N; i++) strobe(8'h81, 6);
        strobe(8'h7F, 6);
        tests++;
        if (o_taps !== exp_taps() || o_sum !== exp_sum() || o_window_full !== 1'b1) begin
            fails++;
            $display("FAIL drop_oldest: taps=%h sum=%0d full=%b, required taps=%h sum=%0d full=1",
                     o_taps, o_sum, o_window_full, exp_taps(), exp_sum());
        end
        $display("[TB] drop_oldest taps=%h sum=%0d", o_taps, o_sum);
    endtask

    task automatic test_decim();
        do_reset();
        i_decim = 4'd2;
        decim_m = 2;
        for (int i = 1; i <= 6; i++) begin
            strobe(8'(8'h80 + i), 6);
            tests++;
            if (o_taps !== exp_taps() || o_sum !== exp_sum()) begin
                fails++;
                $display("FAIL decim[%0d]: taps=%h sum=%0d, required taps=%h sum=%0d",
                         i, o_taps, o_sum, exp_taps(), exp_sum());
            end
            $display("[TB] decim strobe %0d taps=%h", i, o_taps);
        end
        // A strobe held high for 50 cycles must be accepted once only.
        i_decim = '0;
        decim_m = 0;
        strobe(8'h90, 50);
        tests++;
        if (o_taps !== exp_taps() || o_sum !== exp_sum()) begin
            fails++;
            $display("FAIL level_hold: taps=%h sum=%0d, required taps=%h sum=%0d",
                     o_taps, o_sum, exp_taps(), exp_sum());
        end
        $display("[TB] level_hold taps=%h", o_taps);
    endtask

    task automatic test_overrun_clear();
        int base;
        do_reset();
        i_fir_ready = 1'b0;
        base = start_cnt;
        for (int i = 0; i < N; i++) strobe(8'(8'h81 + i), 6);
        tests++;
        if (o_overrun !== 1'b0) begin
            fails++;
            $display("FAIL overrun_early: overrun=%b, required 0", o_overrun);
        end
        strobe(8'hA0, 6);
        strobe(8'hA1, 6);
        tests++;
        if (o_overrun !== 1'b1 || start_cnt - base !== 0) begin
            fails++;
            $display("FAIL overrun_set: overrun=%b pulses=%0d, required 1 and 0",
                     o_overrun, start_cnt - base);
        end
        i_fir_ready = 1'b1;
        repeat (6) @(negedge clk);
        tests++;
        if (start_cnt - base !== 1 || o_taps !== exp_taps() || o_sum !== exp_sum()) begin
            fails++;
            $display("FAIL overrun_release: pulses=%0d taps=%h sum=%0d, required 1 taps=%h sum=%0d",
                     start_cnt - base, o_taps, o_sum, exp_taps(), exp_sum());
        end
        $display("[TB] overrun window taps=%h pulses=%0d", o_taps, start_cnt - base);
        pulse_clear();
        tests++;
        if (o_overrun !== 1'b0 || o_taps !== '0 || o_sum !== '0 || o_window_full !== 1'b0) begin
            fails++;
            $display("FAIL clear: overrun=%b taps=%h sum=%0d full=%b, required all zero",
                     o_overrun, o_taps, o_sum, o_window_full);
        end
        $display("[TB] clear done");
    endtask

    task automatic test_async_reset();
        int base;
        do_reset();
        i_fir_ready = 1'b0;
        for (int i = 0; i <= N; i++) strobe(8'hC3, 6);
        tests++;
        if (o_overrun !== 1'b1 || o_window_full !== 1'b1) begin
            fails++;
            $display("FAIL pre_reset: overrun=%b full=%b, required 1 and 1", o_overrun, o_window_full);
        end
        #2 rst_n = 1'b0;
        #1;
        tests++;
        if (o_taps !== '0 || o_sum !== '0 || o_window_full !== 1'b0 ||
            o_overrun !== 1'b0 || o_start_calc !== 1'b0) begin
            fails++;
            $display("FAIL async_reset: taps=%h sum=%0d full=%b ovr=%b start=%b, required all zero",
                     o_taps, o_sum, o_window_full, o_overrun, o_start_calc);
        end
        @(negedge clk);
        rst_n       = 1'b1;
        i_fir_ready = 1'b1;
        base        = start_cnt;
        model_reset();
        repeat (20) @(negedge clk);
        tests++;
        if (start_cnt - base !== 0) begin
            fails++;
            $display("FAIL async_no_start: pulses=%0d, required 0", start_cnt - base);
        end
        $display("[TB] async reset done");
    endtask

    task automatic test_random();
        int           base;
        logic [B-1:0] v;
        do_reset();
        i_fir_ready = 1'b1;
        decim_m     = int'($urandom_range(0, 2));
        i_decim     = DW'(decim_m);
        exp_pulses  = 0;
        base        = start_cnt;
        for (int i = 0; i < 30; i++) begin
            if (i == 20) pulse_clear();
            v = B'($urandom);
            strobe(v, 6);
            tests++;
            if (o_taps !== exp_taps() || o_sum !== exp_sum() ||
                o_window_full !== (win.size() == N)) begin
                fails++;
                $display("FAIL random[%0d]: taps=%h sum=%0d full=%b, required taps=%h sum=%0d full=%b",
                         i, o_taps, o_sum, o_window_full, exp_taps(), exp_sum(), win.size() == N);
            end
            $display("[TB] random %0d decim=%0d in=%h sum=%0d", i, decim_m, v, o_sum);
        end
        tests++;
        if (start_cnt - base !== exp_pulses) begin
            fails++;
            $display("FAIL random_pulses: pulses=%0d, required %0d", start_cnt - base, exp_pulses);
        end
    endtask

    initial begin
        tests       = 0;
        fails       = 0;
        exp_pulses  = 0;
        rst_n       = 1'b1;
        i_value     = '0;
        i_data_clk  = 1'b0;
        i_decim     = '0;
        i_clear     = 1'b0;
        i_fir_ready = 1'b1;
        decim_m     = 0;
        model_reset();
        #1 rst_n = 1'b0;
        test_reset();
        test_fill();
        test_conversion();
        test_drop_oldest();
        test_decim();
        test_overrun_clear();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
